// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the command master and its testbench.
//   htrans_t     : HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   HSIZE_WORD   : 32-bit transfer size encoding
//   HRESP_OKAY / HRESP_ERROR : HRESP encodings
//   ahb_cmd_t    : one command {write, addr, wdata} at the default 32/32 widths
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } ahb_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with wrap-bit pointers. Read data is the current head
// (show-ahead), so a pop consumes the word already visible on o_rdata.
// Ports:
//   i_clk, i_reset    : clock, asynchronous active-high reset
//   i_push, i_wdata   : write request and data (ignored when full)
//   i_pop             : consume head (ignored when empty)
//   o_rdata           : head entry
//   o_full, o_empty   : occupancy flags
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wrPtr;
    logic [PW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Equal index with differing wrap bits means the writer is a full lap ahead.
    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[PW] != r_rdPtr[PW]) &&
                     (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);

    // Pointer advance; the extra MSB lets full and empty be told apart.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_doPush) r_mem[r_wrPtr[PW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rdPtr[PW-1:0]];

endmodule

// File: rtl/ahb_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_cmd_master
// AHB-Lite master turning a valid/ready command stream into pipelined single
// NONSEQ word transfers, with one response strobe per command.
// Ports:
//   HCLK, HRESETn              : clock, asynchronous active-high reset
//   cmd_valid/ready            : command handshake (push on both high)
//   cmd_write/addr/wdata       : command payload
//   rsp_valid/write/rdata/err  : one-cycle response per command
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA : AHB master outputs
//   HREADY/HRESP/HRDATA        : AHB slave feedback
//   busy                       : FIFO or pipeline holds work
// Build option:
//   AHB_MSTR_STATS_EN adds stat_xfers (completed transfers) and stat_waits
//   (data-phase wait cycles), both 32-bit wrapping counters.
// ---------------------------------------------------------------------------
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA,
`ifdef AHB_MSTR_STATS_EN
    output logic [31:0]           stat_xfers,
    output logic [31:0]           stat_waits,
`endif
    output logic                  busy
);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t                  w_fifoIn;
    cmd_t                  w_fifoHead;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_pipeEmpty;
    logic                  w_advance;
    logic                  w_complete;
    logic                  w_errStart;
    logic                  w_issue;

    logic                  r_readyEn;
    logic                  r_aVld;
    logic                  r_aWrite;
    logic [ADDR_WIDTH-1:0] r_aAddr;
    logic [DATA_WIDTH-1:0] r_aWdata;
    logic                  r_dVld;
    logic                  r_dWrite;
    logic [DATA_WIDTH-1:0] r_dWdata;
    logic                  r_errHold;
    logic                  r_rspValid;
    logic                  r_rspWrite;
    logic [DATA_WIDTH-1:0] r_rspRdata;
    logic                  r_rspErr;

    assign w_fifoIn = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmdFifo (
        .i_clk   (HCLK),
        .i_reset (HRESETn),
        .i_push  (w_push),
        .i_wdata (w_fifoIn),
        .i_pop   (w_pop),
        .o_rdata (w_fifoHead),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign cmd_ready   = r_readyEn && !w_full;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_pipeEmpty = !r_aVld && !r_dVld;

    // With nothing on the bus the A-stage may load without waiting for HREADY;
    // otherwise the pipe only moves on a ready edge outside an error sequence.
    assign w_advance   = (HREADY && !r_errHold) || w_pipeEmpty;
    assign w_pop       = w_advance && !w_empty;
    assign w_complete  = r_dVld && HREADY;
    assign w_errStart  = r_dVld && !HREADY && (HRESP == HRESP_ERROR) && !r_errHold;

    // cmd_ready is held low during reset and opens on the first edge after.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) r_readyEn <= 1'b0;
        else         r_readyEn <= 1'b1;
    end

    // Address and data phase registers. During the error sequence the A-stage
    // is parked (presented as IDLE) and the D-stage retires without refill,
    // so the parked command is reissued once the error completes.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            r_aVld    <= 1'b0;
            r_aWrite  <= 1'b0;
            r_aAddr   <= '0;
            r_aWdata  <= '0;
            r_dVld    <= 1'b0;
            r_dWrite  <= 1'b0;
            r_dWdata  <= '0;
            r_errHold <= 1'b0;
        end else begin
            if (w_advance) begin
                r_dVld <= r_aVld;
                if (r_aVld) begin
                    r_dWrite <= r_aWrite;
                    r_dWdata <= r_aWdata;
                end
                r_aVld <= !w_empty;
                if (!w_empty) begin
                    r_aWrite <= w_fifoHead.write;
                    r_aAddr  <= w_fifoHead.addr;
                    r_aWdata <= w_fifoHead.wdata;
                end
            end else if (w_complete) begin
                r_dVld <= 1'b0;
            end

            if (w_errStart)      r_errHold <= 1'b1;
            else if (w_complete) r_errHold <= 1'b0;
        end
    end

    // Response is registered from the edge that ends the data phase.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            r_rspValid <= 1'b0;
            r_rspWrite <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= w_complete;
            if (w_complete) begin
                r_rspWrite <= r_dWrite;
                r_rspRdata <= r_dWrite ? '0 : HRDATA;
                r_rspErr   <= (HRESP != HRESP_OKAY);
            end
        end
    end

`ifdef AHB_MSTR_STATS_EN
    logic [31:0] r_statXfers;
    logic [31:0] r_statWaits;

    // Free-running wrap-around counters of retired transfers and stall cycles.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            r_statXfers <= '0;
            r_statWaits <= '0;
        end else begin
            if (w_complete)         r_statXfers <= r_statXfers + 32'd1;
            if (r_dVld && !HREADY)  r_statWaits <= r_statWaits + 32'd1;
        end
    end

    assign stat_xfers = r_statXfers;
    assign stat_waits = r_statWaits;
`endif

    assign w_issue   = r_aVld && !r_errHold;
    assign HTRANS    = w_issue ? NONSEQ : IDLE;
    assign HSEL      = w_issue;
    assign HADDR     = r_aAddr;
    assign HWRITE    = r_aWrite;
    assign HSIZE     = HSIZE_WORD;
    assign HWDATA    = r_dWdata;
    assign rsp_valid = r_rspValid;
    assign rsp_write = r_rspWrite;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;
    assign busy      = !w_empty || r_aVld || r_dVld;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_cmd_master
// Directed testbench for ahb_cmd_master. The bench plays the AHB slave by
// driving HREADY/HRESP/HRDATA by hand. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ahb_cmd_master;
    import ahb_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        busy;
`ifdef AHB_MSTR_STATS_EN
    logic [31:0] stat_xfers;
    logic [31:0] stat_waits;
`endif

    int checks = 0;
    int errors = 0;

    ahb_cmd_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
`ifdef AHB_MSTR_STATS_EN
        .stat_xfers(stat_xfers),
        .stat_waits(stat_waits),
`endif
        .busy      (busy)
    );

    // 100 MHz-style free-running clock.
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input ahb_cmd_t c);
        cmd_valid = valid;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic ahb_cmd_t mk(input logic w, input logic [31:0] a,
                                    input logic [31:0] d);
        ahb_cmd_t c;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    // Directed sequence
    initial begin
        ahb_cmd_t idleCmd;
        logic     expWr [7];
        int       sent;
        int       rspCount;
        logic     willPush;

        idleCmd  = mk(1'b0, 32'h0, 32'h0);
        expWr    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        HRESETn  = 1'b1;
        HREADY   = 1'b1;
        HRESP    = HRESP_OKAY;
        HRDATA   = 32'h0;
        applyStimulus(1'b0, idleCmd);

        // 1. Reset values, then cmd_ready opens after release
        step();
        step();
        checkOutput("rst_htrans", HTRANS, 2'b00);
        checkOutput("rst_hsel", HSEL, 1'b0);
        checkOutput("rst_rspvalid", rsp_valid, 1'b0);
        checkOutput("rst_cmdready", cmd_ready, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_hsize", HSIZE, 3'b010);
        HRESETn = 1'b0;
        step();
        checkOutput("rel_cmdready", cmd_ready, 1'b1);

        // 2. Write 0x04 then read it back
        applyStimulus(1'b1, mk(1'b1, 32'h04, 32'hBEEF_BEEF));
        step();
        applyStimulus(1'b0, idleCmd);
        checkOutput("t2_busy", busy, 1'b1);
        checkOutput("t2_idle_before", HTRANS, 2'b00);
        step();
        checkOutput("t2_w_htrans", HTRANS, 2'b10);
        checkOutput("t2_w_haddr", HADDR, 32'h04);
        checkOutput("t2_w_hwrite", HWRITE, 1'b1);
        checkOutput("t2_w_hsel", HSEL, 1'b1);
        step();
        checkOutput("t2_w_hwdata", HWDATA, 32'hBEEF_BEEF);
        checkOutput("t2_w_idle", HTRANS, 2'b00);
        checkOutput("t2_w_norsp", rsp_valid, 1'b0);
        step();
        checkOutput("t2_w_rspvalid", rsp_valid, 1'b1);
        checkOutput("t2_w_rspwrite", rsp_write, 1'b1);
        checkOutput("t2_w_rsperr", rsp_err, HRESP_OKAY);
        checkOutput("t2_w_rsprdata", rsp_rdata, 32'h0);
        applyStimulus(1'b1, mk(1'b0, 32'h04, 32'h0));
        step();
        applyStimulus(1'b0, idleCmd);
        checkOutput("t2_rsp_pulse", rsp_valid, 1'b0);
        step();
        checkOutput("t2_r_htrans", HTRANS, 2'b10);
        checkOutput("t2_r_hwrite", HWRITE, 1'b0);
        step();
        HRDATA = 32'hBEEF_BEEF;
        step();
        HRDATA = 32'h0;
        checkOutput("t2_r_rspvalid", rsp_valid, 1'b1);
        checkOutput("t2_r_rspwrite", rsp_write, 1'b0);
        checkOutput("t2_r_rsprdata", rsp_rdata, 32'hBEEF_BEEF);
        checkOutput("t2_r_busy", busy, 1'b0);

        // 3. Back-to-back writes overlap address and data phases
        applyStimulus(1'b1, mk(1'b1, 32'h10, 32'h1234));
        step();
        applyStimulus(1'b1, mk(1'b1, 32'h14, 32'h4321));
        step();
        applyStimulus(1'b0, idleCmd);
        checkOutput("t3_a1_htrans", HTRANS, 2'b10);
        checkOutput("t3_a1_haddr", HADDR, 32'h10);
        step();
        checkOutput("t3_a2_htrans", HTRANS, 2'b10);
        checkOutput("t3_a2_haddr", HADDR, 32'h14);
        checkOutput("t3_d1_hwdata", HWDATA, 32'h1234);
        step();
        checkOutput("t3_d2_hwdata", HWDATA, 32'h4321);
        checkOutput("t3_idle", HTRANS, 2'b00);
        checkOutput("t3_rsp1", rsp_valid, 1'b1);
        step();
        checkOutput("t3_rsp2", rsp_valid, 1'b1);
        checkOutput("t3_rsp2_write", rsp_write, 1'b1);
        step();
        checkOutput("t3_rsp_end", rsp_valid, 1'b0);

        // 4. Read 0x18 with 3 wait states, write 0x1C held in address phase
        applyStimulus(1'b1, mk(1'b0, 32'h18, 32'h0));
        step();
        applyStimulus(1'b1, mk(1'b1, 32'h1C, 32'h55));
        step();
        applyStimulus(1'b0, idleCmd);
        checkOutput("t4_a_haddr", HADDR, 32'h18);
        step();
        checkOutput("t4_b_haddr", HADDR, 32'h1C);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t4_wait_haddr", HADDR, 32'h1C);
            checkOutput("t4_wait_htrans", HTRANS, 2'b10);
            checkOutput("t4_wait_norsp", rsp_valid, 1'b0);
        end
        HREADY = 1'b1;
        HRDATA = 32'h1234_5678;
        step();
        HRDATA = 32'h0;
        checkOutput("t4_r_rspvalid", rsp_valid, 1'b1);
        checkOutput("t4_r_rsprdata", rsp_rdata, 32'h1234_5678);
        checkOutput("t4_r_rspwrite", rsp_write, 1'b0);
        checkOutput("t4_w_hwdata", HWDATA, 32'h55);
        checkOutput("t4_idle", HTRANS, 2'b00);
        step();
        checkOutput("t4_w_rspvalid", rsp_valid, 1'b1);
        checkOutput("t4_w_rsprdata", rsp_rdata, 32'h0);

        // 5. Two-cycle ERROR on write 0x20 with read 0x24 parked in A-stage
        applyStimulus(1'b1, mk(1'b1, 32'h20, 32'hAA));
        step();
        applyStimulus(1'b1, mk(1'b0, 32'h24, 32'h0));
        step();
        applyStimulus(1'b0, idleCmd);
        step();
        checkOutput("t5_a_haddr", HADDR, 32'h24);
        HRESP  = HRESP_ERROR;
        HREADY = 1'b0;
        step();
        checkOutput("t5_err_htrans", HTRANS, 2'b00);
        checkOutput("t5_err_hsel", HSEL, 1'b0);
        HREADY = 1'b1;
        step();
        HRESP = HRESP_OKAY;
        checkOutput("t5_err_rspvalid", rsp_valid, 1'b1);
        checkOutput("t5_err_rsperr", rsp_err, 1'b1);
        checkOutput("t5_reissue_htrans", HTRANS, 2'b10);
        checkOutput("t5_reissue_haddr", HADDR, 32'h24);
        step();
        checkOutput("t5_dphase_idle", HTRANS, 2'b00);
        HRDATA = 32'h77;
        step();
        HRDATA = 32'h0;
        checkOutput("t5_r_rspvalid", rsp_valid, 1'b1);
        checkOutput("t5_r_rsperr", rsp_err, 1'b0);
        checkOutput("t5_r_rsprdata", rsp_rdata, 32'h77);
`ifdef AHB_MSTR_STATS_EN
        checkOutput("t5_stat_xfers", stat_xfers, 32'd8);
        checkOutput("t5_stat_waits", stat_waits, 32'd4);
`endif

        // Reset in the middle of a transfer abandons it with no response
        applyStimulus(1'b1, mk(1'b1, 32'h30, 32'h99));
        step();
        applyStimulus(1'b0, idleCmd);
        step();
        checkOutput("mr_htrans_pre", HTRANS, 2'b10);
        HRESETn = 1'b1;
        #1;
        checkOutput("mr_htrans", HTRANS, 2'b00);
        checkOutput("mr_busy", busy, 1'b0);
        checkOutput("mr_cmdready", cmd_ready, 1'b0);
        step();
        HRESETn = 1'b0;
        step();
        checkOutput("mr_cmdready_rel", cmd_ready, 1'b1);
        checkOutput("mr_norsp", rsp_valid, 1'b0);
        step();
        checkOutput("mr_norsp2", rsp_valid, 1'b0);
        checkOutput("mr_idle", HTRANS, 2'b00);
`ifdef AHB_MSTR_STATS_EN
        checkOutput("mr_stat_xfers", stat_xfers, 32'd0);
`endif

        // 6. Stalled bus fills the FIFO, then everything drains in order
        HREADY   = 1'b0;
        HRDATA   = 32'hC0DE;
        sent     = 0;
        rspCount = 0;
        for (int c = 0; c < 8; c++) begin
            if (sent < 7) applyStimulus(1'b1, mk(expWr[sent], 32'h40 + 32'(4 * sent), 32'(sent)));
            else          applyStimulus(1'b0, idleCmd);
            willPush = cmd_ready && (sent < 7);
            step();
            if (willPush) sent++;
        end
        checkOutput("t6_accepted", 64'(sent), 64'd5);
        checkOutput("t6_full_ready", cmd_ready, 1'b0);
        checkOutput("t6_held_haddr", HADDR, 32'h40);
        checkOutput("t6_held_htrans", HTRANS, 2'b10);
        HREADY = 1'b1;
        for (int c = 0; c < 40 && rspCount < 7; c++) begin
            if (sent < 7) applyStimulus(1'b1, mk(expWr[sent], 32'h40 + 32'(4 * sent), 32'(sent)));
            else          applyStimulus(1'b0, idleCmd);
            willPush = cmd_ready && (sent < 7);
            step();
            if (willPush) sent++;
            if (rsp_valid) begin
                checkOutput("t6_rsp_write", rsp_write, expWr[rspCount]);
                checkOutput("t6_rsp_rdata", rsp_rdata, expWr[rspCount] ? 32'h0 : 32'hC0DE);
                rspCount++;
            end
        end
        applyStimulus(1'b0, idleCmd);
        checkOutput("t6_rsp_count", 64'(rspCount), 64'd7);
        step();
        checkOutput("t6_busy_end", busy, 1'b0);
`ifdef AHB_MSTR_STATS_EN
        checkOutput("t6_stat_xfers", stat_xfers, 32'd7);
        checkOutput("t6_stat_waits", stat_waits, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
